// File: rtl/binary_linear_sched_pkg.sv
// Shared types and helpers for the binary linear tile scheduler.
package binary_linear_sched_pkg;

  // Scheduler FSM states; also driven out on the debug state port.
  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ISSUE       = 3'd1,
    S_WAIT_CREDIT = 3'd2,
    S_DRAIN       = 3'd3,
    S_DONE        = 3'd4
  } sched_state_t;

  // Address width for a buffer of 'depth' entries, never below one bit.
  function automatic int clamp_addr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tile_credit_counter.sv
// Up/down occupancy counter with full/empty flags. A simultaneous increment
// and decrement leaves the count unchanged; a decrement while empty is
// dropped, and an increment while full saturates.
module tile_credit_counter #(
  parameter int MAX = 2,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [CW-1:0] count_q, count_d;

  assign full_o  = (count_q == CW'(MAX));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Next count: clear wins, then the four inc/dec combinations.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && dec_i) begin
      count_d = empty_o ? count_q + 1'b1 : count_q;
    end else if (inc_i) begin
      count_d = full_o ? count_q : count_q + 1'b1;
    end else if (dec_i) begin
      count_d = empty_o ? count_q : count_q - 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

endmodule

// File: rtl/binary_linear_tile_scheduler.sv
// Tile scheduler for the binary linear datapath: walks cfg_out_tiles output
// tiles, issuing IN_DEPTH paired activation/weight requests per tile, and
// limits tiles in flight with a credit counter fed by the snooped linear
// output handshake. Optional performance counters are built when
// BINARY_LINEAR_SCHED_PERF_EN is defined; otherwise they read as zero.
//
// Handshake: a request transfers on a cycle with req_valid && req_ready;
// req_valid and the request fields hold steady until that transfer. A tile
// retires on lin_out_valid && lin_out_ready, which are only observed here.
module binary_linear_tile_scheduler
  import binary_linear_sched_pkg::*;
#(
  parameter int IN_DEPTH       = 3,
  parameter int MAX_OUT_TILES  = 16,
  parameter int TILE_CREDITS   = 2,
  parameter int ACT_ADDR_WIDTH = clamp_addr_width(IN_DEPTH),
  parameter int WT_ADDR_WIDTH  = clamp_addr_width(MAX_OUT_TILES * IN_DEPTH),
  parameter int PERF_WIDTH     = 32,
  parameter int CFG_W          = $clog2(MAX_OUT_TILES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CFG_W-1:0]          cfg_out_tiles,
  output logic                      busy,
  output logic                      done,
  output logic [ACT_ADDR_WIDTH-1:0] req_act_addr,
  output logic [WT_ADDR_WIDTH-1:0]  req_wt_addr,
  output logic                      req_last,
  output logic                      req_valid,
  input  logic                      req_ready,
  input  logic                      lin_out_valid,
  input  logic                      lin_out_ready,
  output logic [PERF_WIDTH-1:0]     perf_cycles,
  output logic [PERF_WIDTH-1:0]     perf_stalls,
  output sched_state_t              dbg_state
);

  localparam int CRW = $clog2(TILE_CREDITS + 1);

  sched_state_t              state_q, state_d;
  logic [CFG_W-1:0]          cfg_q, cfg_d;
  logic [CFG_W-1:0]          t_q, t_d;
  logic [CFG_W-1:0]          retired_q, retired_d;
  logic [ACT_ADDR_WIDTH-1:0] d_q, d_d;
  logic [WT_ADDR_WIDTH-1:0]  wt_q, wt_d;

  logic [CRW-1:0]            inflight;
  logic                      cnt_full, cnt_empty, cnt_clr;
  logic                      fire, last_chunk, tile_fire, lin_hs, retire;
  logic [CFG_W-1:0]          cfg_sat;

  assign fire       = (state_q == S_ISSUE) && req_ready;
  assign last_chunk = (d_q == ACT_ADDR_WIDTH'(IN_DEPTH - 1));
  assign tile_fire  = fire && last_chunk;
  assign lin_hs     = lin_out_valid && lin_out_ready;
  // A retirement with nothing in flight is dropped.
  assign retire     = lin_hs && !cnt_empty;
  assign cfg_sat    = (cfg_out_tiles > CFG_W'(MAX_OUT_TILES)) ?
                      CFG_W'(MAX_OUT_TILES) : cfg_out_tiles;

  tile_credit_counter #(
    .MAX (TILE_CREDITS),
    .CW  (CRW)
  ) u_inflight (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .inc_i   (tile_fire),
    .dec_i   (lin_hs),
    .count_o (inflight),
    .full_o  (cnt_full),
    .empty_o (cnt_empty)
  );

  // Next-state, address walk and layer bookkeeping.
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    t_d       = t_q;
    d_d       = d_q;
    wt_d      = wt_q;
    retired_d = retired_q + CFG_W'(retire);
    cnt_clr   = 1'b0;

    // The weight address advances linearly: it always equals t*IN_DEPTH+d.
    if (fire) begin
      wt_d = wt_q + 1'b1;
      if (last_chunk) begin
        d_d = '0;
        t_d = t_q + 1'b1;
      end else begin
        d_d = d_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_d     = cfg_sat;
          t_d       = '0;
          d_d       = '0;
          wt_d      = '0;
          retired_d = '0;
          cnt_clr   = 1'b1;
          state_d   = (cfg_sat == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (tile_fire) begin
          if (t_q + 1'b1 == cfg_q) begin
            state_d = S_DRAIN;
          end else if (!retire && inflight == CRW'(TILE_CREDITS - 1)) begin
            // Credits exhaust only if no tile retires in the same cycle.
            state_d = S_WAIT_CREDIT;
          end
        end
      end
      S_WAIT_CREDIT: begin
        if (retire || !cnt_full) state_d = S_ISSUE;
      end
      S_DRAIN: begin
        if (retired_d == cfg_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cfg_q     <= '0;
      t_q       <= '0;
      d_q       <= '0;
      wt_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      t_q       <= t_d;
      d_q       <= d_d;
      wt_q      <= wt_d;
      retired_q <= retired_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign req_valid    = (state_q == S_ISSUE);
  assign req_last     = req_valid && last_chunk;
  assign req_act_addr = d_q;
  assign req_wt_addr  = wt_q;
  assign dbg_state    = state_q;

`ifdef BINARY_LINEAR_SCHED_PERF_EN
  logic [PERF_WIDTH-1:0] perf_cycles_q, perf_stalls_q;

  // Busy-cycle and stall counters; cleared on start, frozen in IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        perf_cycles_q <= '0;
        perf_stalls_q <= '0;
      end
    end else begin
      perf_cycles_q <= perf_cycles_q + 1'b1;
      if (req_valid && !req_ready) perf_stalls_q <= perf_stalls_q + 1'b1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

endmodule
